// File: rtl/id_ex_if.sv
// id_ex_if: decode-stage inputs, hazard sideband and EX-stage outputs of the ID/EX register.
interface id_ex_if #(parameter int XLEN = 32);
  logic            idValid;
  logic [31:0]     idPc;
  logic [XLEN-1:0] idImm;
  logic [4:0]      idRs1Addr, idRs2Addr, idRdAddr;
  logic [XLEN-1:0] idRs1Data, idRs2Data;
  logic [3:0]      idAluControl;
  logic            idSrc1Pc, idSrc2Imm;
  logic            idRegWrite, idMemRead, idMemWrite;
  logic [2:0]      idFunct3;
  logic            stall, flush;
  logic            exMemRegWrite;
  logic [4:0]      exMemRdAddr;
  logic [XLEN-1:0] exMemAluOut;
  logic            memWbRegWrite;
  logic [4:0]      memWbRdAddr;
  logic [XLEN-1:0] memWbData;
  logic            stallReq;
  logic [XLEN-1:0] aluIn1, aluIn2;
  logic [3:0]      aluControl;
  logic            exValid, exRegWrite, exMemRead, exMemWrite;
  logic [4:0]      exRdAddr;
  logic [2:0]      exFunct3;
  logic [31:0]     exPc;
  logic [XLEN-1:0] exStoreData;

  modport master (
    output idValid, idPc, idImm, idRs1Addr, idRs2Addr, idRdAddr, idRs1Data, idRs2Data,
           idAluControl, idSrc1Pc, idSrc2Imm, idRegWrite, idMemRead, idMemWrite, idFunct3,
           stall, flush, exMemRegWrite, exMemRdAddr, exMemAluOut,
           memWbRegWrite, memWbRdAddr, memWbData,
    input  stallReq, aluIn1, aluIn2, aluControl, exValid, exRegWrite, exMemRead, exMemWrite,
           exRdAddr, exFunct3, exPc, exStoreData
  );

  modport slave (
    input  idValid, idPc, idImm, idRs1Addr, idRs2Addr, idRdAddr, idRs1Data, idRs2Data,
           idAluControl, idSrc1Pc, idSrc2Imm, idRegWrite, idMemRead, idMemWrite, idFunct3,
           stall, flush, exMemRegWrite, exMemRdAddr, exMemAluOut,
           memWbRegWrite, memWbRdAddr, memWbData,
    output stallReq, aluIn1, aluIn2, aluControl, exValid, exRegWrite, exMemRead, exMemWrite,
           exRdAddr, exFunct3, exPc, exStoreData
  );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: RV32I ID/EX register with hazard handling; define ID_EX_FORWARDING_EN for
// EX/MEM and MEM/WB forwarding with load-use interlock, otherwise stall on any RAW hazard.
module id_ex_stage #(parameter int XLEN = 32) (
  input logic    clk,
  input logic    rstN,
  id_ex_if.slave bus
);
  localparam logic [3:0] ALU_SLL = 4'b0001, ALU_SRL = 4'b0101, ALU_SRA = 4'b1101;

  typedef struct packed {
    logic            valid, src1_pc, src2_imm, reg_write, mem_read, mem_write;
    logic [2:0]      funct3;
    logic [3:0]      alu_control;
    logic [4:0]      rs1_addr, rs2_addr, rd_addr;
    logic [31:0]     pc;
    logic [XLEN-1:0] imm, rs1_data, rs2_data;
  } st_t;

  st_t st_q, st_d, id_st, held;
  logic [XLEN-1:0] rs1_fwd, rs2_fwd, op2;
  logic use1, use2, stall_req;

  function automatic logic hit(input logic we, input logic [4:0] rd, input logic [4:0] src);
    return we && rd == src && src != 5'd0;
  endfunction

  assign use1 = bus.idValid && !bus.idSrc1Pc;
  assign use2 = bus.idValid && (!bus.idSrc2Imm || bus.idMemWrite);

`ifdef ID_EX_FORWARDING_EN
  assign rs1_fwd = hit(bus.exMemRegWrite, bus.exMemRdAddr, st_q.rs1_addr) ? bus.exMemAluOut :
                   hit(bus.memWbRegWrite, bus.memWbRdAddr, st_q.rs1_addr) ? bus.memWbData : st_q.rs1_data;
  assign rs2_fwd = hit(bus.exMemRegWrite, bus.exMemRdAddr, st_q.rs2_addr) ? bus.exMemAluOut :
                   hit(bus.memWbRegWrite, bus.memWbRdAddr, st_q.rs2_addr) ? bus.memWbData : st_q.rs2_data;
  assign stall_req = st_q.valid && st_q.mem_read &&
                     ((use1 && hit(1'b1, st_q.rd_addr, bus.idRs1Addr)) ||
                      (use2 && hit(1'b1, st_q.rd_addr, bus.idRs2Addr)));
`else
  // Producers in EX or MEM block decode; a WB producer is picked up by the capture bypass.
  assign rs1_fwd = st_q.rs1_data;
  assign rs2_fwd = st_q.rs2_data;
  assign stall_req =
    (use1 && (hit(st_q.valid && st_q.reg_write, st_q.rd_addr, bus.idRs1Addr) ||
              hit(bus.exMemRegWrite, bus.exMemRdAddr, bus.idRs1Addr))) ||
    (use2 && (hit(st_q.valid && st_q.reg_write, st_q.rd_addr, bus.idRs2Addr) ||
              hit(bus.exMemRegWrite, bus.exMemRdAddr, bus.idRs2Addr)));
`endif

  always_comb begin
    id_st = '0;
    if (bus.idValid) begin
      id_st.valid       = 1'b1;
      id_st.src1_pc     = bus.idSrc1Pc;
      id_st.src2_imm    = bus.idSrc2Imm;
      id_st.reg_write   = bus.idRegWrite;
      id_st.mem_read    = bus.idMemRead;
      id_st.mem_write   = bus.idMemWrite;
      id_st.funct3      = bus.idFunct3;
      id_st.alu_control = bus.idAluControl;
      id_st.rs1_addr    = bus.idRs1Addr;
      id_st.rs2_addr    = bus.idRs2Addr;
      id_st.rd_addr     = bus.idRdAddr;
      id_st.pc          = bus.idPc;
      id_st.imm         = bus.idImm;
      id_st.rs1_data    = hit(bus.memWbRegWrite, bus.memWbRdAddr, bus.idRs1Addr) ? bus.memWbData : bus.idRs1Data;
      id_st.rs2_data    = hit(bus.memWbRegWrite, bus.memWbRdAddr, bus.idRs2Addr) ? bus.memWbData : bus.idRs2Data;
    end
    held = st_q;
    held.rs1_data = hit(bus.memWbRegWrite, bus.memWbRdAddr, st_q.rs1_addr) ? bus.memWbData : st_q.rs1_data;
    held.rs2_data = hit(bus.memWbRegWrite, bus.memWbRdAddr, st_q.rs2_addr) ? bus.memWbData : st_q.rs2_data;
    st_d = bus.flush ? '0 : bus.stall ? held : stall_req ? '0 : id_st;
  end

  always_ff @(posedge clk or negedge rstN)
    if (!rstN) st_q <= '0;
    else st_q <= st_d;

  assign op2             = st_q.src2_imm ? st_q.imm : rs2_fwd;
  assign bus.aluIn1      = st_q.src1_pc ? XLEN'(st_q.pc) : rs1_fwd;
  assign bus.aluIn2      = (st_q.alu_control == ALU_SLL || st_q.alu_control == ALU_SRL ||
                            st_q.alu_control == ALU_SRA) ? XLEN'(op2[4:0]) : op2;
  assign bus.aluControl  = st_q.alu_control;
  assign bus.stallReq    = stall_req;
  assign bus.exValid     = st_q.valid;
  assign bus.exRegWrite  = st_q.reg_write;
  assign bus.exMemRead   = st_q.mem_read;
  assign bus.exMemWrite  = st_q.mem_write;
  assign bus.exRdAddr    = st_q.rd_addr;
  assign bus.exFunct3    = st_q.funct3;
  assign bus.exPc        = st_q.pc;
  assign bus.exStoreData = rs2_fwd;
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline stage of the RV32I core. It registers decoded operands and control, resolves data hazards (EX/MEM and MEM/WB forwarding, load-use interlock), and drives the two operand buses and the operation code straight into the ALU. It also produces the forwarded store data and control bits consumed by the EX/MEM register.

## Interface

Parameters

- `XLEN`, 32: datapath width.

Ports

- `clk` in 1: clock, rising edge.
- `rstN` in 1: reset, asynchronous, active-low.
- `idValid`, `idPc[31:0]`, `idImm[31:0]` in: decoded slot valid, PC and immediate.
- `idRs1Addr`, `idRs2Addr`, `idRdAddr` in 5 each: register indices.
- `idRs1Data`, `idRs2Data` in 32 each: register-file read data.
- `idAluControl` in 4: ALU op code, using the shared constant header codes.
- `idSrc1Pc`, `idSrc2Imm` in 1 each: select PC for operand 1, immediate for operand 2.
- `idRegWrite`, `idMemRead`, `idMemWrite` in 1 each; `idFunct3` in 3.
- `stall` in 1: downstream hold. `flush` in 1: branch/jump kill.
- `exMemRegWrite` in 1, `exMemRdAddr` in 5, `exMemAluOut` in 32: MEM-stage result.
- `memWbRegWrite` in 1, `memWbRdAddr` in 5, `memWbData` in 32: WB-stage result.
- `stallReq` out 1: decode must hold, load-use or interlock.
- `aluIn1`, `aluIn2` out 32; `aluControl` out 4: ALU operands and op.
- `exValid`, `exRegWrite`, `exMemRead`, `exMemWrite` out 1; `exRdAddr` out 5; `exFunct3` out 3; `exPc` out 32; `exStoreData` out 32.

## Operation

- Registered state: valid, PC, imm, rs1/rs2/rd addresses, rs1/rs2 data, ALU op, source selects, control bits, funct3.
- Capture bypass: on load, if `memWbRegWrite` and `memWbRdAddr` equals rsN (nonzero), capture `memWbData` instead of `idRsNData`.
- Forwarding, combinational on registered operands: EX/MEM match (regWrite, nonzero rd, rd == rsN) selects `exMemAluOut`. Otherwise a MEM/WB match selects `memWbData`. Otherwise the registered value is used. EX/MEM has priority. x0 is never forwarded.
- `aluIn1` = PC if src1Pc, else forwarded rs1. `aluIn2` = imm if src2Imm, else forwarded rs2.
- For `SLL`/`SRL`/`SRA`, `aluIn2` is zero-extended from bits [4:0].
- `exStoreData` = forwarded rs2, independent of src2Imm.
- Load-use: when `exValid & exMemRead`, exRd nonzero, and it matches an id source that the decoded op uses, assert `stallReq`. rs1 is used unless src1Pc; rs2 is used unless src2Imm, or always when `idMemWrite`.
- `stallReq` is combinational from registered state plus id inputs.

## Timing

- Reset: all registers are 0. Outputs are therefore `exValid`=0, control bits 0, `aluIn1`=`aluIn2`=0, `aluControl`=0, `stallReq`=0.
- Latency: one cycle from id inputs to EX outputs.
- Per-edge priority, highest first:
  - `flush`: load a bubble (all control 0, valid 0).
  - `stall`: hold all registers.
  - `stallReq`: load a bubble; decode holds.
  - Otherwise: load id inputs, with the bubble taken if `idValid`=0.
- While held by `stall`, a cycle with `memWbRegWrite` matching a held rsN (nonzero) overwrites that held data with `memWbData`. This keeps results that retire during a stall.
- `flush` and `stall` asserted together: flush wins.
- `rstN` falling mid-operation clears state immediately, with no clock required.

## Configuration

- `ID_EX_FORWARDING_EN` defined: forwarding and load-use behaviour exactly as above.
- Undefined: no forwarding muxes; operands are the registered values (capture bypass and stall refresh remain).
  - `stallReq` asserts on any RAW hazard: an id source used, nonzero, matching `exRdAddr` with `exValid & exRegWrite`, or matching `exMemRdAddr` with `exMemRegWrite`.
  - The stall repeats until the producer reaches WB.

## Test plan

- Reset released, idle inputs → `exValid`=0, `aluIn1`=`aluIn2`=0, `stallReq`=0 on all cycles.
- addi x1,x0,5 → next cycle `aluIn1`=0, `aluIn2`=5, `exRegWrite`=1. Then add x2,x1,x1 with `exMemAluOut`=5, rd=1 → `aluIn1`=`aluIn2`=5. The forwarding build gives this with zero stall; the non-forwarding build gives `stallReq` for 2 cycles.
- lw x3 in EX, then add x4,x3,x0 at decode → `stallReq`=1 for one cycle, a bubble (`exValid`=0), then the add is loaded and `memWbData`=0x1234 is forwarded to `aluIn1`.
- sll with rs2 value 0x00000123 → `aluIn2`=0x3. Forwarding with rd=x0 and `exMemAluOut`=0xDEAD → operand stays the register value.
- `stall` for 3 cycles while WB writes x5=0x77, where the held instruction reads x5 → after release the operand is 0x77. `flush`+`stall` together → bubble.
- Assert `rstN` low between edges mid-stream → outputs return to 0 immediately.
